uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Parametrised instruction/data loader between the UART receiver and the instruction memory write port.
- Assembles little-endian multi-byte words from the received byte stream and writes them to consecutive memory addresses.
- Stops on a configurable end-marker word and raises write_done.
- Adds inter-byte timeout resync, BREAK abort, capacity overflow detection and optional checksum verification.

Parameters:
- BYTES_PER_WORD, 4, bytes per word (1..8); WORD_W = 8*BYTES_PER_WORD.
- ADDR_W, 8, memory address width; capacity 2^ADDR_W words.
- END_MARKER, all-ones (WORD_W bits), word that terminates a load and is not written.
- TIMEOUT_CYCLES, 50000, idle clk cycles inside a partial word before the partial word is discarded; 0 disables the timeout.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- load_en, input, 1, enables loading; deassertion returns the block to IDLE.
- rx_valid, input, 1, one-cycle strobe, rx_data valid.
- rx_data, input, 8, received byte.
- rx_break, input, 1, UART BREAK detected.
- mem_we, output, 1, one-cycle memory write strobe.
- mem_addr, output, ADDR_W, write address.
- mem_wdata, output, WORD_W, write data.
- word_count, output, ADDR_W+1, number of words written this load.
- busy, output, 1, high in COLLECT.
- write_done, output, 1, sticky, end marker received.
- overflow, output, 1, sticky, a word arrived when memory was full.
- sync_err, output, 1, sticky, a partial word was discarded (timeout or break).

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE. All outputs 0, byte index 0, shift register 0, timeout counter 0.
- IDLE: the block moves to COLLECT when load_en=1. On entry it clears word_count, the address, write_done, overflow, sync_err and the byte index.
- COLLECT, byte handling:
  - On rx_valid, rx_data is placed into byte lane [byte_idx] and byte_idx increments.
  - The timeout counter clears on every accepted byte.
- COLLECT, word completion, when byte_idx = BYTES_PER_WORD-1 and rx_valid:
  - If the assembled word equals END_MARKER: the state moves to DONE on the next cycle, write_done=1, and nothing is written.
  - Else if word_count < 2^ADDR_W: on the next cycle mem_we=1, mem_wdata=word, mem_addr=word_count[ADDR_W-1:0]. word_count increments in the same cycle as mem_we.
  - Else: the word is dropped and overflow=1.
  - byte_idx returns to 0.
- Latency: mem_we is asserted exactly 1 clk after the rx_valid of the final byte. mem_addr and mem_wdata are valid only while mem_we=1 and hold their last value otherwise.
- Timeout: with byte_idx != 0 and no rx_valid for TIMEOUT_CYCLES consecutive cycles, byte_idx goes to 0, the partial word is discarded and sync_err=1. With byte_idx = 0 the counter does not run.
- BREAK: rx_break=1 in COLLECT discards the partial word. sync_err=1 only if byte_idx != 0. The state stays COLLECT.
- Simultaneous rx_break and rx_valid: the break wins and the byte is discarded.
- DONE: the state is held and rx bytes are ignored. write_done, word_count and the sticky flags hold. load_en=0 moves the state to IDLE; outputs hold until the next entry to COLLECT.
- load_en=0 mid-COLLECT: the state goes to IDLE on the next cycle. The partial word is discarded without setting sync_err. Words already written remain and word_count holds.
- Address wrap: the address never wraps. Capacity is exhausted at word_count = 2^ADDR_W, after which the overflow rule applies.
- mem_we is never asserted outside COLLECT and is never asserted for END_MARKER.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - Adds output checksum_ok (1 bit, reset 0).
  - A WORD_W running sum, modulo 2^WORD_W, accumulates every written word.
  - After END_MARKER the block enters CHK and treats the next complete word as the checksum; it is not written.
  - checksum_ok=1 if the received checksum equals the two's complement negation of the sum, else 0. write_done rises when the checksum word completes, not on the marker.
  - Timeout and BREAK behaviour in CHK is the same as in COLLECT.
- Disabled: no CHK state, no checksum_ok port. write_done rises on the marker.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, COLLECT, CHK, DONE);
  - the default END_MARKER and TIMEOUT_CYCLES constants;
  - a function computing WORD_W from BYTES_PER_WORD.
- One sub-module: byte_assembler, containing the shift register, byte_idx, timeout counter and break/timeout discard. It outputs word_valid and word.
- The top level holds the FSM, address/count, flags and checksum.

Test Plan:
- BYTES_PER_WORD=4: send bytes 13 01 01 FB, then FF FF FF FF -> mem_we once with addr 0, wdata 0xFB010113; write_done=1; word_count=1.
- Send 3 bytes AA BB CC, idle TIMEOUT_CYCLES+1 cycles, then 23 26 81 04 -> sync_err=1; single write at addr 0 with wdata 0x04812623.
- ADDR_W=2: send 5 non-marker words then the marker -> 4 writes at addrs 0..3; overflow=1; word_count=4; write_done=1.
- Assert rx_break after 2 bytes, then send a full word -> partial bytes discarded; sync_err=1; correct word written at addr 0.
- Drop load_en mid-word then raise it again -> no write for the partial word; flags and word_count cleared on re-entry; the next word goes to addr 0.
- LOADER_CHECKSUM_EN: send words 1, 2, the marker, then 0xFFFFFFFD -> checksum_ok=1 and write_done=1. Repeating with checksum 0 -> checksum_ok=0.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and defaults for the UART word loader
// Contents: loader state enum, default END_MARKER / TIMEOUT_CYCLES values,
//           word_width() helper giving WORD_W from BYTES_PER_WORD.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHK     = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

    // Wide enough for the largest word (8 bytes); callers slice to WORD_W.
    localparam logic [63:0] DEFAULT_END_MARKER     = '1;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 50000;

    function automatic int word_width(input int bytes_per_word);
        return 8 * bytes_per_word;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - little-endian byte-to-word assembler with timeout/break resync
// Ports: clk, resetn (async active-low); enable (collecting, clears the partial
//        word when low); rx_valid/rx_data/rx_break (UART receiver side);
//        word_valid/word (combinational, high in the cycle of the final byte);
//        discard (combinational, a partial word is being thrown away by a
//        timeout or a break).
module byte_assembler
    import loader_pkg::*;
#(
    parameter  int BYTES_PER_WORD = 4,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int WORD_W         = word_width(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              discard
);

    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [WORD_W-1:0] shift_reg;
    logic [IDX_W-1:0]  byte_idx;
    logic [TO_W-1:0]   to_cnt;
    logic              partial;
    logic              timeout_hit;

    assign partial = (byte_idx != '0);

    // to_cnt counts idle cycles already seen; the TIMEOUT_CYCLES-th idle cycle fires.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && enable && partial &&
                         !rx_valid && !rx_break && (to_cnt == TO_LAST);

    // Break beats a simultaneous byte, so the final byte only counts without one.
    assign word_valid = enable && rx_valid && !rx_break && (byte_idx == LAST_IDX);
    assign discard    = enable && partial && (rx_break || timeout_hit);

    // The completed word includes the byte arriving this cycle.
    always_comb begin
        word = shift_reg;
        word[byte_idx*8 +: 8] = rx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
        end else if (!enable || rx_break || timeout_hit) begin
            byte_idx <= '0;
            to_cnt   <= '0;
        end else if (rx_valid) begin
            shift_reg[byte_idx*8 +: 8] <= rx_data;
            byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
            to_cnt   <= '0;
        end else if (partial && (TIMEOUT_CYCLES != 0)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - loads UART byte stream as words into instruction memory
// Ports: clk, resetn (async active-low); load_en; rx_valid/rx_data/rx_break from
//        the UART receiver; mem_we/mem_addr/mem_wdata memory write port;
//        word_count, busy, write_done, overflow, sync_err status; checksum_ok
//        (only when LOADER_CHECKSUM_EN is defined).
// Optional: define LOADER_CHECKSUM_EN to expect a checksum word after the marker.
module uart_word_loader
    import loader_pkg::*;
#(
    parameter  int BYTES_PER_WORD = 4,
    parameter  int ADDR_W         = 8,
    parameter  logic [word_width(BYTES_PER_WORD)-1:0] END_MARKER =
                   DEFAULT_END_MARKER[word_width(BYTES_PER_WORD)-1:0],
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int WORD_W         = word_width(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
`ifdef LOADER_CHECKSUM_EN
    output logic              checksum_ok,
`endif
    output logic              busy,
    output logic              write_done,
    output logic              overflow,
    output logic              sync_err
);

    loader_state_t     state;
    logic              asm_enable;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              discard;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] neg_sum;
    assign neg_sum = '0 - sum;
`endif

    // Dropping load_en clears the partial word in the same cycle, with no sync_err.
    assign asm_enable = load_en && ((state == ST_COLLECT) || (state == ST_CHK));

    byte_assembler #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (asm_enable),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_break   (rx_break),
        .word_valid (word_valid),
        .word       (word),
        .discard    (discard)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            write_done <= 1'b0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum         <= '0;
            checksum_ok <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_en) begin
                        state      <= ST_COLLECT;
                        busy       <= 1'b1;
                        word_count <= '0;
                        mem_addr   <= '0;
                        write_done <= 1'b0;
                        overflow   <= 1'b0;
                        sync_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum         <= '0;
                        checksum_ok <= 1'b0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (!load_en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (discard) sync_err <= 1'b1;
                        if (word_valid) begin
                            if (word == END_MARKER) begin
                                busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                                state <= ST_CHK;
`else
                                state      <= ST_DONE;
                                write_done <= 1'b1;
`endif
                            end else if (!word_count[ADDR_W]) begin
                                // MSB of word_count set means all 2^ADDR_W slots are used.
                                mem_we     <= 1'b1;
                                mem_addr   <= word_count[ADDR_W-1:0];
                                mem_wdata  <= word;
                                word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                                sum <= sum + word;
`endif
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (!load_en) begin
                        state <= ST_IDLE;
                    end else begin
                        if (discard) sync_err <= 1'b1;
                        if (word_valid) begin
                            checksum_ok <= (word == neg_sum);
                            write_done  <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (!load_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - directed self-checking bench for uart_word_loader
module tb_uart_word_loader;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load_en;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_break;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  word_count;
    logic        busy;
    logic        write_done;
    logic        overflow;
    logic        sync_err;
`ifdef LOADER_CHECKSUM_EN
    logic        checksum_ok;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    int          wr_total = 0;
    logic [1:0]  log_addr [0:63];
    logic [31:0] log_data [0:63];

    always #5 clk = ~clk;

    uart_word_loader #(
        .BYTES_PER_WORD (4),
        .ADDR_W         (2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
`ifdef LOADER_CHECKSUM_EN
        .checksum_ok (checksum_ok),
`endif
        .resetn      (resetn),
        .load_en     (load_en),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_break    (rx_break),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .word_count  (word_count),
        .busy        (busy),
        .write_done  (write_done),
        .overflow    (overflow),
        .sync_err    (sync_err)
    );

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_total < 64) begin
                log_addr[wr_total] = mem_addr;
                log_data[wr_total] = mem_wdata;
            end
            wr_total++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_break();
        rx_break = 1'b1;
        @(posedge clk);
        #1;
        rx_break = 1'b0;
    endtask

    task automatic start_load();
        load_en = 1'b0;
        idle(2);
        load_en = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        resetn = 1'b0; load_en = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
        idle(3);
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        tests_run++; if (word_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", word_count); end
        tests_run++; if ({busy, write_done, overflow, sync_err} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {busy, write_done, overflow, sync_err}); end
        tests_run++; if ({mem_addr, mem_wdata} !== 34'd0) begin tests_failed++; $display("FAIL reset_port: got %h expected 0", {mem_addr, mem_wdata}); end
        resetn = 1'b1;
        idle(2);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int base;
        start_load();
        base = wr_total;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", busy); end
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h01);
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL basic_early_we: got %b expected 0", mem_we); end
        send_byte(8'hFB);
        tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL basic_latency_we: got %b expected 1", mem_we); end
        tests_run++; if (mem_addr !== 2'd0) begin tests_failed++; $display("FAIL basic_addr: got %0d expected 0", mem_addr); end
        tests_run++; if (mem_wdata !== 32'hFB010113) begin tests_failed++; $display("FAIL basic_wdata: got %h expected fb010113", mem_wdata); end
        idle(1);
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL basic_we_pulse: got %b expected 0", mem_we); end
        tests_run++; if (mem_wdata !== 32'hFB010113) begin tests_failed++; $display("FAIL basic_wdata_hold: got %h expected fb010113", mem_wdata); end
        send_word(32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h00000000);
`endif
        idle(1);
        tests_run++; if (write_done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %b expected 1", write_done); end
        tests_run++; if (word_count !== 3'd1) begin tests_failed++; $display("FAIL basic_count: got %0d expected 1", word_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
        send_word(32'h12345678);
        idle(1);
        tests_run++; if (wr_total - base !== 1) begin tests_failed++; $display("FAIL basic_writes: got %0d expected 1", wr_total - base); end
        tests_run++; if (word_count !== 3'd1) begin tests_failed++; $display("FAIL done_hold_count: got %0d expected 1", word_count); end
    endtask

    task automatic test_timeout();
        int base;
        start_load();
        base = wr_total;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        idle(T - 1);
        tests_run++; if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got %b expected 0", sync_err); end
        idle(2);
        tests_run++; if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_sync_err: got %b expected 1", sync_err); end
        send_byte(8'h23); send_byte(8'h26); send_byte(8'h81); send_byte(8'h04);
        idle(1);
        tests_run++; if (wr_total - base !== 1) begin tests_failed++; $display("FAIL timeout_writes: got %0d expected 1", wr_total - base); end
        tests_run++; if (log_addr[base] !== 2'd0) begin tests_failed++; $display("FAIL timeout_addr: got %0d expected 0", log_addr[base]); end
        tests_run++; if (log_data[base] !== 32'h04812623) begin tests_failed++; $display("FAIL timeout_wdata: got %h expected 04812623", log_data[base]); end
    endtask

    task automatic test_timeout_boundary();
        int base;
        start_load();
        base = wr_total;
        send_byte(8'h11); send_byte(8'h22);
        idle(T - 1);
        send_byte(8'h33); send_byte(8'h44);
        idle(1);
        tests_run++; if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_bound_sync_err: got %b expected 0", sync_err); end
        tests_run++; if (wr_total - base !== 1) begin tests_failed++; $display("FAIL tmo_bound_writes: got %0d expected 1", wr_total - base); end
        tests_run++; if (log_data[base] !== 32'h44332211) begin tests_failed++; $display("FAIL tmo_bound_wdata: got %h expected 44332211", log_data[base]); end
    endtask

    task automatic test_overflow();
        int base;
        start_load();
        base = wr_total;
        for (int k = 1; k <= 4; k++) send_word(32'h11111111 * k);
        idle(1);
        tests_run++; if (word_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_full_count: got %0d expected 4", word_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        send_word(32'h55555555);
        idle(1);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        send_word(32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h00000000);
`endif
        idle(1);
        tests_run++; if (write_done !== 1'b1) begin tests_failed++; $display("FAIL ovf_done: got %b expected 1", write_done); end
        tests_run++; if (word_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 4", word_count); end
        tests_run++; if (wr_total - base !== 4) begin tests_failed++; $display("FAIL ovf_writes: got %0d expected 4", wr_total - base); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (log_addr[base+k] !== 2'(k) || log_data[base+k] !== 32'h11111111 * (k + 1)) begin tests_failed++; $display("FAIL ovf_write%0d: got %0d/%h expected %0d/%h", k, log_addr[base+k], log_data[base+k], k, 32'h11111111 * (k + 1)); end
        end
    endtask

    task automatic test_break();
        int base;
        start_load();
        base = wr_total;
        pulse_break();
        tests_run++; if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL break_idle_idx: got %b expected 0", sync_err); end
        send_byte(8'h01); send_byte(8'h02);
        rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h99;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_break = 1'b0;
        tests_run++; if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL break_sync_err: got %b expected 1", sync_err); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL break_stays: got %b expected 1", busy); end
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        idle(1);
        tests_run++; if (wr_total - base !== 1) begin tests_failed++; $display("FAIL break_writes: got %0d expected 1", wr_total - base); end
        tests_run++; if (log_addr[base] !== 2'd0 || log_data[base] !== 32'hEFBEADDE) begin tests_failed++; $display("FAIL break_word: got %0d/%h expected 0/efbeadde", log_addr[base], log_data[base]); end
    endtask

    task automatic test_load_drop();
        int base;
        start_load();
        base = wr_total;
        send_byte(8'h5A);
        pulse_break();
        send_word(32'h40302010);
        send_byte(8'h77); send_byte(8'h88);
        load_en = 1'b0;
        idle(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy: got %b expected 0", busy); end
        tests_run++; if (word_count !== 3'd1) begin tests_failed++; $display("FAIL drop_count_hold: got %0d expected 1", word_count); end
        tests_run++; if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL drop_sync_hold: got %b expected 1", sync_err); end
        tests_run++; if (wr_total - base !== 1) begin tests_failed++; $display("FAIL drop_writes: got %0d expected 1", wr_total - base); end
        load_en = 1'b1;
        idle(1);
        tests_run++; if (word_count !== 3'd0) begin tests_failed++; $display("FAIL reentry_count: got %0d expected 0", word_count); end
        tests_run++; if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL reentry_sync_err: got %b expected 0", sync_err); end
        send_word(32'h0D0C0B0A);
        idle(1);
        tests_run++; if (wr_total - base !== 2) begin tests_failed++; $display("FAIL reentry_writes: got %0d expected 2", wr_total - base); end
        tests_run++; if (log_addr[base+1] !== 2'd0 || log_data[base+1] !== 32'h0D0C0B0A) begin tests_failed++; $display("FAIL reentry_word: got %0d/%h expected 0/0d0c0b0a", log_addr[base+1], log_data[base+1]); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        start_load();
        send_word(32'h00000001); send_word(32'h00000002); send_word(32'hFFFFFFFF);
        idle(1);
        tests_run++; if (write_done !== 1'b0) begin tests_failed++; $display("FAIL chk_done_early: got %b expected 0", write_done); end
        send_word(32'hFFFFFFFD);
        idle(1);
        tests_run++; if (checksum_ok !== 1'b1) begin tests_failed++; $display("FAIL chk_ok: got %b expected 1", checksum_ok); end
        tests_run++; if (write_done !== 1'b1) begin tests_failed++; $display("FAIL chk_done: got %b expected 1", write_done); end
        start_load();
        send_word(32'h00000001); send_word(32'h00000002); send_word(32'hFFFFFFFF);
        send_word(32'h00000000);
        idle(1);
        tests_run++; if (checksum_ok !== 1'b0) begin tests_failed++; $display("FAIL chk_bad: got %b expected 0", checksum_ok); end
        tests_run++; if (write_done !== 1'b1) begin tests_failed++; $display("FAIL chk_bad_done: got %b expected 1", write_done); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_timeout_boundary();
        test_overflow();
        test_break();
        test_load_drop();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
